// File: rtl/axis_pair_mac.sv
// Pairwise multiply-accumulate over AXI4-Stream frames; the 2W-bit dot product
// leaves as two beats (low word, then high word carrying last).
module axis_pair_mac #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic                  s_axis_valid,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  output logic                  s_axis_ready,
  input  logic                  s_axis_last,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic                  odd_err
);

  localparam int AW = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_A,
    ST_B,
    ST_DRAIN,
    ST_LO,
    ST_HI
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [AW-1:0]         p_q, p_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic                  pv_q, pv_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  send;

  // All outputs are pure decodes of registered state.
  always_comb begin
    s_axis_ready = (state_q == ST_A) || (state_q == ST_B);
    m_axis_valid = (state_q == ST_LO) || (state_q == ST_HI);
    m_axis_last  = (state_q == ST_HI);
    m_axis_data  = '0;
    if (state_q == ST_LO) begin
      m_axis_data = acc_q[DATA_WIDTH-1:0];
    end else if (state_q == ST_HI) begin
      m_axis_data = acc_q[AW-1:DATA_WIDTH];
    end
    frame_count = cnt_q;
    odd_err     = err_q;
  end

  assign accept = s_axis_valid && s_axis_ready;
  assign send   = m_axis_valid && m_axis_ready;

  // The product lands in acc one cycle after the B accept; ST_DRAIN covers the
  // final pair so acc is settled before ST_LO presents it.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    p_d     = p_q;
    pv_d    = 1'b0;
    acc_d   = pv_q ? (acc_q + p_q) : acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_A: begin
        if (accept) begin
          a_d = s_axis_data;
          if (s_axis_last) begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_B;
          end
        end
      end
      ST_B: begin
        if (accept) begin
          p_d     = AW'(a_q) * AW'(s_axis_data);
          pv_d    = 1'b1;
          state_d = s_axis_last ? ST_DRAIN : ST_A;
        end
      end
      ST_DRAIN: state_d = ST_LO;
      ST_LO: begin
        if (send) state_d = ST_HI;
      end
      ST_HI: begin
        if (send) begin
          acc_d   = '0;
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_A;
        end
      end
      default: state_d = ST_A;
    endcase
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q <= ST_A;
      a_q     <= '0;
      p_q     <= '0;
      pv_q    <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      p_q     <= p_d;
      pv_q    <= pv_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axis_pair_mac.sv
// Scoreboard bench for axis_pair_mac: expected beats are queued as frames are
// driven and matched against beats captured from the output handshake.
module tb_axis_pair_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic [15:0] fc;
  logic        oe;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  logic [31:0] frm[$];
  bit          gaps = 1'b0;

  axis_pair_mac #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .axi_clk      (clk),
    .axi_reset    (rst),
    .s_axis_valid (s_valid),
    .s_axis_data  (s_data),
    .s_axis_ready (s_ready),
    .s_axis_last  (s_last),
    .m_axis_valid (m_valid),
    .m_axis_data  (m_data),
    .m_axis_ready (m_ready),
    .m_axis_last  (m_last),
    .frame_count  (fc),
    .odd_err      (oe)
  );

  always #5 clk = ~clk;

  // A beat seen valid&&ready at the negedge is consumed at the next posedge.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) obs_q.push_back({m_last, m_data});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [31:0] d, input logic l);
    int unsigned cyc = 0;
    if (gaps) begin
      int unsigned g = $urandom_range(0, 3);
      repeat (g) begin @(posedge clk); #1; end
    end
    s_valid = 1'b1; s_data = d; s_last = l;
    @(negedge clk);
    while (!s_ready && cyc < 2000) begin @(negedge clk); cyc++; end
    if (!s_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: s_axis_ready got 0 need 1 after %0d cycles", cyc);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame();
    foreach (frm[i]) send_word(frm[i], i == frm.size() - 1);
  endtask

  task automatic wait_obs(input int n, output bit ok);
    int c = 0;
    while (obs_q.size() < n && c < 500) begin @(posedge clk); #1; c++; end
    ok = (obs_q.size() >= n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete(); obs_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({s_ready, m_valid, m_last, fc, oe} !== {1'b1, 1'b0, 1'b0, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_in: got rdy=%0b v=%0b l=%0b fc=%0d err=%0b need 1 0 0 0 0",
               s_ready, m_valid, m_last, fc, oe);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({s_ready, m_valid, m_last, fc, oe} !== {1'b1, 1'b0, 1'b0, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_out: got rdy=%0b v=%0b l=%0b fc=%0d err=%0b need 1 0 0 0 0",
               s_ready, m_valid, m_last, fc, oe);
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [32:0] e, o;
    m_ready = 1'b1;
    frm = '{32'd3, 32'd5, 32'd7, 32'd11};
    exp_q.push_back({1'b0, 32'h0000005C});  // 3*5 + 7*11 = 92
    exp_q.push_back({1'b1, 32'h00000000});
    send_frame();
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++; $display("FAIL t1_drain_valid: got %0b need 0", m_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (m_valid !== 1'b1) begin
      n_fail++; $display("FAIL t1_latency_valid: got %0b need 1", m_valid);
    end
    wait_obs(exp_q.size(), ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL t1_timeout: got %0d beats need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL t1_beat: got last=%0b data=%h need last=%0b data=%h", o[32], o[31:0], e[32], e[31:0]);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_checks++;
    if ({fc, oe} !== {16'd1, 1'b0}) begin
      n_fail++; $display("FAIL t1_status: got fc=%0d err=%0b need fc=1 err=0", fc, oe);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [32:0] e, o;
    frm = '{32'hFFFFFFFF, 32'hFFFFFFFF};
    exp_q.push_back({1'b0, 32'h00000001});
    exp_q.push_back({1'b1, 32'hFFFFFFFE});
    send_frame();
    frm = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    exp_q.push_back({1'b0, 32'h00000004});
    exp_q.push_back({1'b1, 32'hFFFFFFF8});
    send_frame();
    wait_obs(exp_q.size(), ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL t2_timeout: got %0d beats need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL t2_beat: got last=%0b data=%h need last=%0b data=%h", o[32], o[31:0], e[32], e[31:0]);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_checks++;
    if (fc !== 16'd3) begin
      n_fail++; $display("FAIL t2_count: got %0d need 3", fc);
    end
  endtask

  task automatic test_odd_frame();
    bit ok;
    logic [32:0] e, o;
    frm = '{32'd2, 32'd3, 32'd4};
    exp_q.push_back({1'b0, 32'h00000006});
    exp_q.push_back({1'b1, 32'h00000000});
    send_frame();
    wait_obs(exp_q.size(), ok);
    n_checks++;
    if (oe !== 1'b1) begin
      n_fail++; $display("FAIL t3_err_set: got %0b need 1", oe);
    end
    frm = '{32'd1, 32'd1};
    exp_q.push_back({1'b0, 32'h00000001});
    exp_q.push_back({1'b1, 32'h00000000});
    send_frame();
    wait_obs(exp_q.size(), ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL t3_timeout: got %0d beats need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL t3_beat: got last=%0b data=%h need last=%0b data=%h", o[32], o[31:0], e[32], e[31:0]);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_checks++;
    if ({fc, oe} !== {16'd5, 1'b1}) begin
      n_fail++; $display("FAIL t3_status: got fc=%0d err=%0b need fc=5 err=1", fc, oe);
    end
  endtask

  task automatic test_backpressure();
    int c = 0;
    logic [32:0] e, o;
    m_ready = 1'b0;
    frm = '{32'd3, 32'd5, 32'd7, 32'd11};
    exp_q.push_back({1'b0, 32'h0000005C});
    exp_q.push_back({1'b1, 32'h00000000});
    send_frame();
    while (!m_valid && c < 100) begin @(posedge clk); #1; c++; end
    n_checks++;
    if (!m_valid) begin
      n_fail++; $display("FAIL t4_valid_timeout: m_axis_valid got 0 need 1");
    end
    repeat (10) begin
      @(negedge clk); n_checks++;
      if ({m_valid, m_last, s_ready, m_data} !== {1'b1, 1'b0, 1'b0, 32'h5C}) begin
        n_fail++; $display("FAIL t4_lo_hold: got v=%0b l=%0b rdy=%0b d=%h need 1 0 0 0000005c",
                           m_valid, m_last, s_ready, m_data);
      end
    end
    @(posedge clk); #1; m_ready = 1'b1;
    @(posedge clk); #1; m_ready = 1'b0;
    repeat (3) begin
      @(negedge clk); n_checks++;
      if ({m_valid, m_last, s_ready, m_data} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
        n_fail++; $display("FAIL t4_hi_hold: got v=%0b l=%0b rdy=%0b d=%h need 1 1 0 00000000",
                           m_valid, m_last, s_ready, m_data);
      end
    end
    @(posedge clk); #1; m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 2) begin
      n_fail++; $display("FAIL t4_beat_count: got %0d beats need 2", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL t4_beat: got last=%0b data=%h need last=%0b data=%h", o[32], o[31:0], e[32], e[31:0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random_frames();
    bit ok;
    logic [32:0] e, o;
    logic [63:0] sum;
    do_reset();
    m_ready = 1'b1;
    gaps = 1'b1;
    repeat (200) begin
      frm.delete();
      repeat (8) frm.push_back($urandom);
      sum = '0;
      for (int i = 0; i + 1 < 8; i += 2) sum += 64'(frm[i]) * 64'(frm[i+1]);
      exp_q.push_back({1'b0, sum[31:0]});
      exp_q.push_back({1'b1, sum[63:32]});
      send_frame();
    end
    gaps = 1'b0;
    wait_obs(exp_q.size(), ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL t5_timeout: got %0d beats need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL t5_beat: got last=%0b data=%h need last=%0b data=%h", o[32], o[31:0], e[32], e[31:0]);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_checks++;
    if ({fc, oe} !== {16'd200, 1'b0}) begin
      n_fail++; $display("FAIL t5_status: got fc=%0d err=%0b need fc=200 err=0", fc, oe);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int c = 0;
    logic [32:0] e, o;
    frm = '{32'd9};
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b1, 32'h0});
    send_frame();
    wait_obs(exp_q.size(), ok);
    exp_q.delete(); obs_q.delete();
    send_word(32'd3, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({s_ready, m_valid, m_last, m_data, fc, oe} !== {1'b1, 1'b0, 1'b0, 32'h0, 16'd0, 1'b0}) begin
      n_fail++; $display("FAIL t6_reset_b: got rdy=%0b v=%0b l=%0b d=%h fc=%0d err=%0b need 1 0 0 0 0 0",
                         s_ready, m_valid, m_last, m_data, fc, oe);
    end
    @(posedge clk); #1; rst = 1'b0;
    m_ready = 1'b0;
    frm = '{32'd3, 32'd5, 32'd7, 32'd11};
    send_frame();
    while (!m_valid && c < 100) begin @(posedge clk); #1; c++; end
    @(posedge clk); #1; m_ready = 1'b1;
    @(posedge clk); #1; m_ready = 1'b0;
    n_checks++;
    if ({m_valid, m_last} !== 2'b11) begin
      n_fail++; $display("FAIL t6_in_hi: got v=%0b l=%0b need 1 1", m_valid, m_last);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({m_valid, m_last, m_data, s_ready, fc} !== {1'b0, 1'b0, 32'h0, 1'b1, 16'd0}) begin
      n_fail++; $display("FAIL t6_reset_hi: got v=%0b l=%0b d=%h rdy=%0b fc=%0d need 0 0 0 1 0",
                         m_valid, m_last, m_data, s_ready, fc);
    end
    @(posedge clk); #1;
    exp_q.delete(); obs_q.delete();
    rst = 1'b0;
    m_ready = 1'b1;
    exp_q.push_back({1'b0, 32'h0000005C});
    exp_q.push_back({1'b1, 32'h00000000});
    send_frame();
    wait_obs(exp_q.size(), ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL t6_timeout: got %0d beats need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL t6_beat: got last=%0b data=%h need last=%0b data=%h", o[32], o[31:0], e[32], e[31:0]);
      end
    end
    n_checks++;
    if (fc !== 16'd1) begin
      n_fail++; $display("FAIL t6_count: got %0d need 1", fc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_odd_frame();
    test_backpressure();
    test_random_frames();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
